// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit multiplexed 7-seg scan with blanking gap and shared decoder.
// Optional digit blinking is compiled in with `define DISP_BLINK_EN.
module display_scan_ctrl #(
    parameter int DIGIT_CYC    = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  dec_in,
    input  logic [7:0]  dec_out,
    output logic [3:0]  an,
    output logic [7:0]  cat,
    output logic        frame_tick
);
    localparam int CW = $clog2(DIGIT_CYC);
    typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;
    state_t state;
    logic [1:0] idx;
    logic [CW-1:0] cnt;
    logic [3:0] lit_an;
`ifdef DISP_BLINK_EN
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    logic [FW-1:0] frames;
    logic phase;
    logic unused_bits;
    assign unused_bits = dec_out[7];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames <= '0;
            phase  <= 1'b0;
        end else if (!enable) begin
            frames <= '0;
            phase  <= 1'b0;
        end else if (frame_tick) begin
            frames <= (frames == FW'(BLINK_FRAMES - 1)) ? '0 : frames + 1'b1;
            phase  <= (frames == FW'(BLINK_FRAMES - 1)) ? ~phase : phase;
        end
    end
    assign lit_an = (phase && blink_mask[idx]) ? 4'hF : ~(4'b1 << idx);
`else
    logic unused_bits;
    assign unused_bits = ^{blink_mask, dec_out[7]};
    assign lit_an = ~(4'b1 << idx);
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 2'd0;
            cnt        <= '0;
            dec_in     <= 4'h0;
            an         <= 4'hF;
            cat        <= 8'hFF;
            frame_tick <= 1'b0;
        end else if (!enable) begin
            state      <= IDLE;
            idx        <= 2'd0;
            cnt        <= '0;
            an         <= 4'hF;
            cat        <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            // registered one cycle early so the pulse lands on the slot's last cycle
            frame_tick <= state != IDLE && idx == 2'd3 && cnt == CW'(DIGIT_CYC - 2);
            case (state)
                IDLE: begin
                    state <= BLANK;
                    idx   <= 2'd0;
                    cnt   <= '0;
                end
                BLANK: begin
                    if (cnt == '0) dec_in <= bcd_in[4*idx +: 4];
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(BLANK_CYC - 1)) begin
                        state <= ON;
                        cat   <= {~dp_mask[idx], dec_out[6:0]};
                        an    <= lit_an;
                    end
                end
                ON: begin
                    if (cnt == CW'(DIGIT_CYC - 1)) begin
                        cnt   <= '0;
                        idx   <= idx + 1'b1;
                        state <= BLANK;
                        an    <= 4'hF;
                        cat   <= 8'hFF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed + random stimulus against a time-based model of the scan.
module tb_display_scan_ctrl;
    localparam int D = 8;
    localparam int B = 2;
    localparam int BF = 2;
`ifdef DISP_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic [15:0] bcd_in = 16'h0;
    logic [3:0] dp_mask = 4'h0;
    logic [3:0] blink_mask = 4'h0;
    logic [3:0] dec_in;
    logic [7:0] dec_out;
    logic [3:0] an;
    logic [7:0] cat;
    logic frame_tick;
    int checks = 0;
    int errors = 0;
    bit active = 1'b0;
    int t = 0;
    logic [3:0] digit = 4'h0;
    logic [3:0] exp_dec = 4'h0;
    bit dp = 1'b0;
    bit dark = 1'b0;
    logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    display_scan_ctrl #(.DIGIT_CYC(D), .BLANK_CYC(B), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bcd_in(bcd_in), .dp_mask(dp_mask),
        .blink_mask(blink_mask), .dec_in(dec_in), .dec_out(dec_out), .an(an), .cat(cat),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seg(input logic [3:0] v);
        return (v < 4'd10) ? seg_tbl[v] : 8'hFF;
    endfunction

    assign dec_out = seg(dec_in);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h at t=%0d", tag, got, exp, $time);
        end
    endtask

    // Expected outputs follow from the position inside the frame since the scan started.
    task automatic compare();
        int pos = t % D;
        int slot = (t / D) % 4;
        logic [3:0] ea = 4'hF;
        logic [7:0] ec = 8'hFF;
        logic [7:0] s = seg(digit);
        logic ef = 1'b0;
        if (active) begin
            ea = (pos >= B && !dark) ? ~(4'b1 << slot) : 4'hF;
            ec = (pos >= B) ? {~dp, s[6:0]} : 8'hFF;
            ef = (slot == 3 && pos == D - 1);
        end
        check("an", an, ea);
        check("cat", cat, ec);
        check("frame_tick", frame_tick, ef);
        check("dec_in", dec_in, exp_dec);
    endtask

    task automatic step();
        @(posedge clk);
        if (!enable) begin
            active = 1'b0;
        end else if (!active) begin
            active = 1'b1;
            t = 0;
        end else begin
            int pos = t % D;
            int slot = (t / D) % 4;
            if (pos == 0) begin
                digit = bcd_in[4*slot +: 4];
                exp_dec = digit;
            end
            if (pos == B - 1) begin
                dp = dp_mask[slot];
                dark = BLINK && (((t / (4 * D)) / BF) % 2 == 1) && blink_mask[slot];
            end
            t++;
        end
        @(negedge clk);
        compare();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic seek_on(input int slot);
        int n = 0;
        while (!(active && (t % D) >= B && (t / D) % 4 == slot) && n < 64) begin
            step();
            n++;
        end
        check("seek_on_timeout", n < 64, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        compare();
        rst_n = 1'b1;
        run(20);
        enable = 1'b1;
        bcd_in = 16'h1234;
        run(64);
        dp_mask = 4'b0100;
        run(21);
        bcd_in[11:8] = 4'h7;
        run(40);
        bcd_in[3:0] = 4'hA;
        run(32);
        dp_mask[0] = 1'b1;
        run(32);
        blink_mask = 4'b0001;
        run(160);
        seek_on(1);
        enable = 1'b0;
        step();
        run(5);
        enable = 1'b1;
        run(12);
        seek_on(2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_an", an, 4'hF);
        check("rst_cat", cat, 8'hFF);
        check("rst_dec_in", dec_in, 4'h0);
        check("rst_frame_tick", frame_tick, 1'b0);
        active = 1'b0;
        exp_dec = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        run(40);
        repeat (800) begin
            if ($urandom_range(0, 5) == 0) bcd_in = 16'($urandom);
            if ($urandom_range(0, 20) == 0) dp_mask = 4'($urandom);
            if ($urandom_range(0, 40) == 0) blink_mask = 4'($urandom);
            enable = ($urandom_range(0, 150) != 0);
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
